// File: rtl/memoria_pkg.sv
// memoria_pkg: shared definitions for the memory arbiter.
//   estado_t        - arbiter FSM encoding (LIBRE, ACCESO, RESP)
//   ANCHO_BYTE/PALABRA - access width codes carried on *_width / mem_width
//   MAX_ESPERA_DEF  - default number of consecutive fetch losses tolerated
//   desalineado()   - true for a word access whose address is not word aligned
package memoria_pkg;

    typedef enum logic [1:0] {
        LIBRE  = 2'd0,
        ACCESO = 2'd1,
        RESP   = 2'd2
    } estado_t;

    localparam logic ANCHO_BYTE    = 1'b0;
    localparam logic ANCHO_PALABRA = 1'b1;

    localparam int MAX_ESPERA_DEF = 4;

    // Byte accesses can never be misaligned; word accesses need dir[1:0] == 0.
    function automatic logic desalineado(input logic ancho, input logic [1:0] dir_lsb);
        return (ancho == ANCHO_PALABRA) && (dir_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/arbitro_memoria_if.sv
// arbitro_memoria_if: bundle of the fetch port, the load/store port and the
// memoria port of the arbiter.
//   modport slave  - the arbiter: takes requests and mem_Out, drives acks/data/mem_*
//   modport master - the environment (requesters plus memoria): the opposite side
// Handshake: a requester raises *_req with its address/data stable and holds
// everything until it sees *_ack high for one cycle; ack, err and dato are
// valid together in that cycle. A request still high after the ack is a new one.
interface arbitro_memoria_if;
    // fetch port
    logic        if_req;
    logic [31:0] if_dir;
    logic        if_ack;
    logic        if_err;
    logic [31:0] if_dato;
    // load/store port
    logic        ls_req;
    logic        ls_we;
    logic        ls_width;
    logic [31:0] ls_dir;
    logic [31:0] ls_in;
    logic        ls_ack;
    logic        ls_err;
    logic [31:0] ls_dato;
    // memoria port
    logic [31:0] mem_dir;
    logic        mem_width;
    logic        mem_WEn;
    logic [31:0] mem_in;
    logic [31:0] mem_Out;

    modport slave (
        input  if_req, if_dir,
        output if_ack, if_err, if_dato,
        input  ls_req, ls_we, ls_width, ls_dir, ls_in,
        output ls_ack, ls_err, ls_dato,
        output mem_dir, mem_width, mem_WEn, mem_in,
        input  mem_Out
    );

    modport master (
        output if_req, if_dir,
        input  if_ack, if_err, if_dato,
        output ls_req, ls_we, ls_width, ls_dir, ls_in,
        input  ls_ack, ls_err, ls_dato,
        input  mem_dir, mem_width, mem_WEn, mem_in,
        output mem_Out
    );

endinterface

// File: rtl/arbitro_memoria_contador_espera.sv
// contador_espera: fetch starvation counter.
//   clock, reset  - system clock, synchronous active-high reset
//   if_req_i      - fetch request level
//   if_pierde_i   - fetch requested in LIBRE but load/store was granted
//   if_gana_i     - fetch granted this cycle
//   lleno_o       - counter has reached MAX_ESPERA: fetch must win next time
module contador_espera
    import memoria_pkg::*;
#(
    parameter int MAX_ESPERA = MAX_ESPERA_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic if_req_i,
    input  logic if_pierde_i,
    input  logic if_gana_i,
    output logic lleno_o
);

    localparam int CW = (MAX_ESPERA < 1) ? 1 : $clog2(MAX_ESPERA + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_ESPERA);

    logic [CW-1:0] cuenta_q, cuenta_d;

    // While a transaction is in flight (neither loss nor grant) the count holds,
    // so only arbitration decisions move it.
    always_comb begin
        cuenta_d = cuenta_q;
        if (!if_req_i || if_gana_i) begin
            cuenta_d = '0;
        end else if (if_pierde_i && (cuenta_q != MAXC)) begin
            cuenta_d = cuenta_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign lleno_o = (cuenta_q == MAXC);

endmodule

// File: rtl/arbitro_memoria.sv
// arbitro_memoria: shares one memoria port between an instruction fetch port
// and a load/store port.
//   clock, reset   - system clock, synchronous active-high reset
//   bus            - arbitro_memoria_if.slave: fetch, load/store and memoria signals
//   estado_dbg_o   - current FSM state for observation
// Each transaction takes LIBRE -> ACCESO -> RESP: request sampled in LIBRE,
// memory accessed in ACCESO, one-cycle ack in RESP. Load/store normally wins;
// fetch wins once it has lost MAX_ESPERA times in a row.
module arbitro_memoria
    import memoria_pkg::*;
#(
    parameter int MAX_ESPERA = MAX_ESPERA_DEF
) (
    input  logic                clock,
    input  logic                reset,
    arbitro_memoria_if.slave    bus,
    output estado_t             estado_dbg_o
);

    estado_t     estado_q, estado_d;
    logic [31:0] dir_q, dir_d;
    logic        we_q, we_d;
    logic        ancho_q, ancho_d;
    logic [31:0] dato_q, dato_d;
    logic        es_if_q, es_if_d;
    logic        mal_q, mal_d;
    logic        if_ack_q, if_ack_d;
    logic        if_err_q, if_err_d;
    logic [31:0] if_dato_q, if_dato_d;
    logic        ls_ack_q, ls_ack_d;
    logic        ls_err_q, ls_err_d;
    logic [31:0] ls_dato_q, ls_dato_d;

    logic        libre;
    logic        lleno;
    logic        if_gana;
    logic        if_pierde;
    logic [31:0] captura;

    assign libre     = (estado_q == LIBRE);
    assign if_gana   = libre && bus.if_req && (!bus.ls_req || lleno);
    assign if_pierde = libre && bus.if_req && bus.ls_req && !if_gana;
    // A misaligned word access reads as zero instead of memory contents.
    assign captura   = mal_q ? 32'd0 : bus.mem_Out;

    contador_espera #(
        .MAX_ESPERA (MAX_ESPERA)
    ) u_contador (
        .clock       (clock),
        .reset       (reset),
        .if_req_i    (bus.if_req),
        .if_pierde_i (if_pierde),
        .if_gana_i   (if_gana),
        .lleno_o     (lleno)
    );

    always_comb begin
        estado_d  = estado_q;
        dir_d     = dir_q;
        we_d      = we_q;
        ancho_d   = ancho_q;
        dato_d    = dato_q;
        es_if_d   = es_if_q;
        mal_d     = mal_q;
        if_ack_d  = 1'b0;
        if_err_d  = 1'b0;
        if_dato_d = if_dato_q;
        ls_ack_d  = 1'b0;
        ls_err_d  = 1'b0;
        ls_dato_d = ls_dato_q;

        case (estado_q)
            LIBRE: begin
                if (if_gana) begin
                    // Fetch is always a word read.
                    dir_d    = bus.if_dir;
                    we_d     = 1'b0;
                    ancho_d  = ANCHO_PALABRA;
                    dato_d   = 32'd0;
                    es_if_d  = 1'b1;
                    mal_d    = desalineado(ANCHO_PALABRA, bus.if_dir[1:0]);
                    estado_d = ACCESO;
                end else if (bus.ls_req) begin
                    dir_d    = bus.ls_dir;
                    we_d     = bus.ls_we;
                    ancho_d  = bus.ls_width;
                    dato_d   = bus.ls_in;
                    es_if_d  = 1'b0;
                    mal_d    = desalineado(bus.ls_width, bus.ls_dir[1:0]);
                    estado_d = ACCESO;
                end
            end
            ACCESO: begin
                // Ack/err/dato registered here so they appear together in RESP.
                estado_d = RESP;
                if (es_if_q) begin
                    if_ack_d  = 1'b1;
                    if_err_d  = mal_q;
                    if_dato_d = captura;
                end else begin
                    ls_ack_d  = 1'b1;
                    ls_err_d  = mal_q;
                    ls_dato_d = captura;
                end
            end
            RESP: begin
                estado_d = LIBRE;
            end
            default: begin
                estado_d = LIBRE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= LIBRE;
            dir_q     <= 32'd0;
            we_q      <= 1'b0;
            ancho_q   <= 1'b0;
            dato_q    <= 32'd0;
            es_if_q   <= 1'b0;
            mal_q     <= 1'b0;
            if_ack_q  <= 1'b0;
            if_err_q  <= 1'b0;
            if_dato_q <= 32'd0;
            ls_ack_q  <= 1'b0;
            ls_err_q  <= 1'b0;
            ls_dato_q <= 32'd0;
        end else begin
            estado_q  <= estado_d;
            dir_q     <= dir_d;
            we_q      <= we_d;
            ancho_q   <= ancho_d;
            dato_q    <= dato_d;
            es_if_q   <= es_if_d;
            mal_q     <= mal_d;
            if_ack_q  <= if_ack_d;
            if_err_q  <= if_err_d;
            if_dato_q <= if_dato_d;
            ls_ack_q  <= ls_ack_d;
            ls_err_q  <= ls_err_d;
            ls_dato_q <= ls_dato_d;
        end
    end

    // The write strobe is gated by reset combinationally so a reset arriving
    // mid-ACCESO prevents the write on that very edge.
    assign bus.mem_WEn   = (estado_q == ACCESO) && we_q && !mal_q && !reset;
    assign bus.mem_dir   = dir_q;
    assign bus.mem_width = ancho_q;
    assign bus.mem_in    = dato_q;

    assign bus.if_ack  = if_ack_q;
    assign bus.if_err  = if_err_q;
    assign bus.if_dato = if_dato_q;
    assign bus.ls_ack  = ls_ack_q;
    assign bus.ls_err  = ls_err_q;
    assign bus.ls_dato = ls_dato_q;

    assign estado_dbg_o = estado_q;

endmodule

// File: doc/arbitro_memoria.md
ARBITRO_MEMORIA -- requirements
Module: arbitro_memoria

Interface
REQ-001 SHALL have parameter MAX_ESPERA, default 4, meaning consecutive fetch losses before fetch is forced to win.
REQ-002 SHALL have port clock  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port if_req  in  1  fetch request, held until if_ack.
REQ-005 SHALL have port if_dir  in  32  fetch byte address.
REQ-006 SHALL have ports if_ack  out  1 and if_err  out  1  fetch completion and misalignment flag.
REQ-007 SHALL have port if_dato  out  32  fetched word.
REQ-008 SHALL have ports ls_req  in  1, ls_we  in  1 (1 = store), ls_width  in  1 (0 = byte, 1 = word).
REQ-009 SHALL have ports ls_dir  in  32 and ls_in  in  32  load/store address and store data.
REQ-010 SHALL have ports ls_ack  out  1, ls_err  out  1, ls_dato  out  32  load/store completion, misalignment flag, load data.
REQ-011 SHALL have ports mem_dir  out  32, mem_width  out  1, mem_WEn  out  1 (1 = write), mem_in  out  32  to memoria.
REQ-012 SHALL have port mem_Out  in  32  memoria read data, combinational from mem_dir.

Function
REQ-013 SHALL implement FSM LIBRE -> ACCESO -> RESP -> LIBRE; LIBRE stays LIBRE with no request pending.
REQ-014 In LIBRE with any request, SHALL choose a winner, latch its dir/we/width/data, and enter ACCESO next cycle.
REQ-015 Arbitration SHALL favour ls over if, except fetch wins when the starvation counter equals MAX_ESPERA.
REQ-016 Starvation counter SHALL increment when if_req loses in LIBRE, clear when fetch is granted or if_req is low, and saturate at MAX_ESPERA.
REQ-017 In ACCESO, SHALL drive latched address/width/data on mem_*, assert mem_WEn only for an aligned store, and capture mem_Out.
REQ-018 Fetch SHALL always use mem_width = 1 and mem_WEn = 0.
REQ-019 In RESP, SHALL pulse the winner's ack for exactly one cycle with captured data; the loser's ack stays 0.
REQ-020 Latency SHALL be fixed: request sampled in LIBRE at cycle N, ack at N+2; next request sampled at N+3.
REQ-021 Word access with dir[1:0] != 0 SHALL perform no memory write, assert err with ack, and return data 0.
REQ-022 Byte access SHALL never be flagged misaligned.
REQ-023 Once granted, a transaction SHALL complete even if req deasserts; req still high after ack SHALL count as a new request.
REQ-024 Outside ACCESO, mem_WEn SHALL be 0; mem_dir/mem_width/mem_in SHALL hold their last latched values.
REQ-025 if_dato/ls_dato SHALL hold their value until that port's next ack.

Reset
REQ-026 On reset, SHALL set state LIBRE, acks/errs 0, datos 0, counter 0, all latches 0, and mem_WEn 0.
REQ-027 mem_WEn SHALL be gated with ~reset so no write commits on an edge where reset is high, including mid-ACCESO.
REQ-028 A transaction interrupted by reset SHALL be dropped without ack; the requester reissues.

Structure
REQ-029 State encoding, width codes (ANCHO_BYTE = 0, ANCHO_PALABRA = 1), and the default MAX_ESPERA SHALL live in shared package memoria_pkg.
REQ-030 The starvation counter SHALL be sub-module contador_espera; all else is in arbitro_memoria.

Verification
REQ-031 Store then load: ls_we=1, ls_width=1, ls_dir=8, ls_in=136; then load dir 8 -> ls_ack at N+2 both times, ls_dato=136.
REQ-032 Byte store: word 0xAABBCCDD at dir 12, then byte store 0x11 -> a word load returns the value memoria defines for byte writes; mem_width=0 seen in ACCESO.
REQ-033 Contention: if_req and ls_req held high continuously, MAX_ESPERA=4 -> grants ls,ls,ls,ls,if, repeating.
REQ-034 Misaligned: word store to dir 6 -> mem_WEn never 1, ls_err=1 with ls_ack, ls_dato=0; word at dir 4 unchanged.
REQ-035 Reset in ACCESO of a store to dir 16 -> no write (dir 16 keeps old value), no ack, state LIBRE, all outputs 0 next cycle.
REQ-036 Fetch-only: if_dir stepping 0, 4, 8 with req held -> if_ack every 3 cycles, if_dato matches memoria contents.
